// File: rtl/matmul_sequencer.sv
// matmul_sequencer: 2x2 C = A x B on one shared multiplier, two cycles per element, done pulse 8 cycles after start.
// start is ignored while busy; define MATMUL_SIGNED_EN for two's-complement operands (default unsigned).
module matmul_sequencer #(
  parameter int W = 4,
  localparam int OUT_W = 2*W+1
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             start,
  input  logic [W-1:0]     A00,
  input  logic [W-1:0]     A01,
  input  logic [W-1:0]     A10,
  input  logic [W-1:0]     A11,
  input  logic [W-1:0]     B00,
  input  logic [W-1:0]     B01,
  input  logic [W-1:0]     B10,
  input  logic [W-1:0]     B11,
  output logic [OUT_W-1:0] C00,
  output logic [OUT_W-1:0] C01,
  output logic [OUT_W-1:0] C10,
  output logic [OUT_W-1:0] C11,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, MUL_LO, MUL_HI} state_t;

  state_t                  state, state_nxt;
  logic [3:0][W-1:0]       a_q, b_q;
  logic [2*W-1:0]          acc;
  logic [1:0]              k;
  logic [3:0][OUT_W-1:0]   c_q;
  logic                    done_nxt;
  logic                    load;
  logic                    hi;
  logic [W-1:0]            mul_a, mul_b;
  logic [2*W-1:0]          prod;
  logic                    acc_x, prod_x;
  logic [OUT_W-1:0]        sum;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = MUL_LO;
        end
      end
      MUL_LO: state_nxt = MUL_HI;
      MUL_HI: begin
        if (k == 2'd3) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = MUL_LO;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Element k = {i,j}: LO phase uses A[i][0]*B[0][j], HI phase A[i][1]*B[1][j].
  assign hi    = (state == MUL_HI);
  assign mul_a = a_q[{k[1], hi}];
  assign mul_b = b_q[{hi, k[0]}];

`ifdef MATMUL_SIGNED_EN
  assign prod   = $signed({{W{mul_a[W-1]}}, mul_a}) * $signed({{W{mul_b[W-1]}}, mul_b});
  assign acc_x  = acc[2*W-1];
  assign prod_x = prod[2*W-1];
`else
  assign prod   = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
  assign acc_x  = 1'b0;
  assign prod_x = 1'b0;
`endif

  assign sum = {acc_x, acc} + {prod_x, prod};

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      a_q  <= '0;
      b_q  <= '0;
      acc  <= '0;
      k    <= '0;
      c_q  <= '0;
      done <= 1'b0;
    end else begin
      done <= done_nxt;
      if (load) begin
        a_q <= {A11, A10, A01, A00};
        b_q <= {B11, B10, B01, B00};
        c_q <= '0;
        k   <= '0;
      end
      if (state == MUL_LO) acc <= prod;
      if (state == MUL_HI) begin
        c_q[k] <= sum;
        if (k != 2'd3) k <= k + 2'd1;
      end
    end
  end

  assign C00 = c_q[0];
  assign C01 = c_q[1];
  assign C10 = c_q[2];
  assign C11 = c_q[3];

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: directed and random runs against a plain-arithmetic matrix model.
module tb_matmul_sequencer;

  localparam int W = 4;
  localparam int OUT_W = 2*W+1;

  logic clk = 1'b0;
  logic nRST = 1'b0;
  logic start = 1'b0;
  logic [W-1:0] A00 = '0, A01 = '0, A10 = '0, A11 = '0;
  logic [W-1:0] B00 = '0, B01 = '0, B10 = '0, B11 = '0;
  logic [OUT_W-1:0] C00, C01, C10, C11;
  logic busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matmul_sequencer #(.W(W)) dut (
    .clk(clk), .nRST(nRST), .start(start),
    .A00(A00), .A01(A01), .A10(A10), .A11(A11),
    .B00(B00), .B01(B01), .B10(B10), .B11(B11),
    .C00(C00), .C01(C01), .C10(C10), .C11(C11),
    .busy(busy), .done(done)
  );

  // Element n of a packed matrix: 0=[0][0], 1=[0][1], 2=[1][0], 3=[1][1].
  function automatic int el(input logic [15:0] m, input int n);
    logic [3:0] t;
    t = m[4*n +: 4];
`ifdef MATMUL_SIGNED_EN
    return int'($signed(t));
`else
    return int'({28'd0, t});
`endif
  endfunction

  function automatic logic [31:0] ref_c(input logic [15:0] a, input logic [15:0] b, input int idx);
    int i, j;
    logic [31:0] s;
    i = idx / 2;
    j = idx % 2;
    s = el(a, 2*i) * el(b, j) + el(a, 2*i+1) * el(b, 2+j);
    return {23'd0, s[8:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b);
    {A11, A10, A01, A00} = a;
    {B11, B10, B01, B00} = b;
  endtask

  function automatic logic [31:0] c_obs(input int idx);
    case (idx)
      0: return {23'd0, C00};
      1: return {23'd0, C01};
      2: return {23'd0, C10};
      default: return {23'd0, C11};
    endcase
  endfunction

  task automatic chk_all_c(input string tag, input logic [15:0] a, input logic [15:0] b, input bit zero);
    for (int n = 0; n < 4; n++)
      chk($sformatf("%s_c%0d", tag, n), c_obs(n), zero ? 32'd0 : ref_c(a, b, n));
  endtask

  // Full run: start accepted at edge N, then every cycle through N+9 checked.
  // glitch: a second start with other data at edge N+3 must be ignored.
  task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b, input bit glitch);
    drive(a, b);
    start = 1'b1;
    tick();
    start = 1'b0;
    drive(16'($urandom), 16'($urandom));
    chk({tag, "_busy0"}, {31'd0, busy}, 32'd1);
    chk_all_c({tag, "_clr"}, a, b, 1'b1);
    for (int m = 1; m <= 9; m++) begin
      if (glitch && m == 3) begin
        start = 1'b1;
        drive(16'($urandom), 16'($urandom));
      end
      tick();
      start = 1'b0;
      chk($sformatf("%s_busy%0d", tag, m), {31'd0, busy}, {31'd0, (m < 8)});
      chk($sformatf("%s_done%0d", tag, m), {31'd0, done}, {31'd0, (m == 8)});
      for (int n = 0; n < 4; n++)
        chk($sformatf("%s_m%0d_c%0d", tag, m, n), c_obs(n),
            (2*(n+1) <= m) ? ref_c(a, b, n) : 32'd0);
    end
  endtask

  initial begin
    logic [15:0] a, b;
    bit seen;

    // Reset state
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk_all_c("rst", 16'd0, 16'd0, 1'b1);
    tick();
    nRST = 1'b1;
    tick();

    // Reference example and saturation corner
    run("basic", 16'h4321, 16'h8765, 1'b0);
    run("max", 16'hFFFF, 16'hFFFF, 1'b0);

    // Mid-run start ignored, snapshot kept
    run("glitch", 16'h2A5C, 16'h7E19, 1'b1);

    // start held high: back-to-back runs every 9 cycles
    a = 16'h3B1F;
    b = 16'hC2D4;
    drive(a, b);
    start = 1'b1;
    tick();
    for (int m = 1; m <= 20; m++) begin
      tick();
      chk($sformatf("held_done%0d", m), {31'd0, done}, {31'd0, (m == 8 || m == 17)});
      chk($sformatf("held_busy%0d", m), {31'd0, busy}, {31'd0, !(m == 8 || m == 17)});
      if (m == 9)  chk_all_c("held_clr", a, b, 1'b1);
      if (m == 8 || m == 17) chk_all_c($sformatf("held_res%0d", m), a, b, 1'b0);
    end
    start = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      tick();
      seen = done;
    end
    chk("held_drain_done", {31'd0, seen}, 32'd1);
    tick();

    // Reset mid-run
    drive(16'h9999, 16'h5555);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int m = 1; m <= 5; m++) tick();
    nRST = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk_all_c("midrst", 16'd0, 16'd0, 1'b1);
    tick();
    nRST = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      seen = seen | done;
    end
    chk("midrst_nodone", {31'd0, seen}, 32'd0);
    run("after_rst", 16'h1234, 16'hFEDC, 1'b0);

    // Sign-sensitive corner: A00=F, B00=1
    run("sign", 16'h000F, 16'h0001, 1'b0);

    // Random runs
    for (int r = 0; r < 20; r++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      run($sformatf("rnd%0d", r), a, b, (r % 4) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
